// File: rtl/uart8_core_if.sv
// Byte-side and serial-pin signals of uart8_core, bundled for module ports.
// Handshake: txStart offers txIn; it is taken on an edge where the core is idle and txEn=1, seen as txBusy=1 after that edge. rxDone is a 1-clk valid strobe with no back-pressure.
interface uart8_core_if;
  logic       rxEn;
  logic       rxIn;
  logic       rxBusy;
  logic       rxDone;
  logic       rxErr;
  logic [7:0] rxOut;
  logic       txEn;
  logic       txStart;
  logic [7:0] txIn;
  logic       txBusy;
  logic       txDone;
  logic       txOut;
  logic [1:0] rxState;
  logic [1:0] txState;

  modport master (
    output rxEn, rxIn, txEn, txStart, txIn,
    input  rxBusy, rxDone, rxErr, rxOut, txBusy, txDone, txOut, rxState, txState
  );
  modport slave (
    input  rxEn, rxIn, txEn, txStart, txIn,
    output rxBusy, rxDone, rxErr, rxOut, txBusy, txDone, txOut, rxState, txState
  );
endinterface

// File: rtl/uart8_core.sv
// 8N1 UART: 16x-oversampling receiver and 1x-baud transmitter, fully independent.
// rxState/txState expose the FSM states (0 idle, 1 start, 2 data, 3 stop).
module uart8_core #(
  parameter int CLOCK_RATE = 12000000,
  parameter int BAUD_RATE  = 9600
) (
  input logic         clk,
  input logic         rst,
  uart8_core_if.slave bus
);
  localparam int RXDIV = (CLOCK_RATE + 8 * BAUD_RATE) / (16 * BAUD_RATE);
  localparam int TXDIV = (CLOCK_RATE + BAUD_RATE / 2) / BAUD_RATE;
  localparam int RXW   = $clog2(RXDIV);
  localparam int TXW   = $clog2(TXDIV);
  localparam logic [RXW-1:0] RXLAST = RXW'(RXDIV - 1);
  localparam logic [TXW-1:0] TXLAST = TXW'(TXDIV - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} stateT;

  // Receiver state
  stateT          rxSt;
  logic           rxMeta;
  logic           rxSync;
  logic [RXW-1:0] rxDivCnt;
  logic [3:0]     rxTickCnt;
  logic [2:0]     rxBitCnt;
  logic [7:0]     rxShift;
  logic           rxBusyR;
  logic           rxDoneR;
  logic           rxErrR;
  logic [7:0]     rxOutR;
  logic           rxTick;

  // Transmitter state
  stateT          txSt;
  logic [TXW-1:0] txDivCnt;
  logic [2:0]     txBitCnt;
  logic [7:0]     txShift;
  logic           txBusyR;
  logic           txDoneR;
  logic           txOutR;

  assign rxTick = (rxSt != IDLE) && (rxDivCnt == RXLAST);

  // Two-stage synchroniser; resets to the idle-high line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      rxMeta <= 1'b1;
      rxSync <= 1'b1;
    end else begin
      rxMeta <= bus.rxIn;
      rxSync <= rxMeta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rxSt      <= IDLE;
      rxDivCnt  <= '0;
      rxTickCnt <= '0;
      rxBitCnt  <= '0;
      rxShift   <= '0;
      rxBusyR   <= 1'b0;
      rxDoneR   <= 1'b0;
      rxErrR    <= 1'b0;
      rxOutR    <= 8'h00;
    end else begin
      rxDoneR <= 1'b0;
      rxErrR  <= 1'b0;
      if (!bus.rxEn) begin
        rxSt      <= IDLE;
        rxBusyR   <= 1'b0;
        rxDivCnt  <= '0;
        rxTickCnt <= '0;
      end else begin
        if (rxSt != IDLE) begin
          if (rxTick) rxDivCnt <= '0;
          else        rxDivCnt <= rxDivCnt + RXW'(1);
        end
        case (rxSt)
          IDLE: begin
            if (!rxSync) begin
              rxSt      <= START;
              rxDivCnt  <= '0;
              rxTickCnt <= '0;
            end
          end
          START: begin
            if (rxTick) begin
              if (rxTickCnt == 4'd7) begin
                rxTickCnt <= '0;
                if (!rxSync) begin
                  rxSt     <= DATA;
                  rxBusyR  <= 1'b1;
                  rxBitCnt <= '0;
                end else begin
                  rxSt <= IDLE;
                end
              end else begin
                rxTickCnt <= rxTickCnt + 4'd1;
              end
            end
          end
          DATA: begin
            if (rxTick) begin
              rxTickCnt <= rxTickCnt + 4'd1;
              if (rxTickCnt == 4'd15) begin
                rxShift  <= {rxSync, rxShift[7:1]};
                rxBitCnt <= rxBitCnt + 3'd1;
                if (rxBitCnt == 3'd7) rxSt <= STOP;
              end
            end
          end
          default: begin
            // Leave at mid-stop so a start edge right after it is not missed.
            if (rxTick) begin
              rxTickCnt <= rxTickCnt + 4'd1;
              if (rxTickCnt == 4'd15) begin
                rxSt    <= IDLE;
                rxBusyR <= 1'b0;
                if (rxSync) begin
                  rxOutR  <= rxShift;
                  rxDoneR <= 1'b1;
                end else begin
                  rxErrR <= 1'b1;
                end
              end
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      txSt     <= IDLE;
      txDivCnt <= '0;
      txBitCnt <= '0;
      txShift  <= '0;
      txBusyR  <= 1'b0;
      txDoneR  <= 1'b0;
      txOutR   <= 1'b1;
    end else begin
      txDoneR <= 1'b0;
      if (!bus.txEn) begin
        txSt     <= IDLE;
        txBusyR  <= 1'b0;
        txOutR   <= 1'b1;
        txDivCnt <= '0;
      end else if (txSt == IDLE) begin
        txOutR <= 1'b1;
        if (bus.txStart) begin
          txShift  <= bus.txIn;
          txBusyR  <= 1'b1;
          txOutR   <= 1'b0;
          txDivCnt <= '0;
          txSt     <= START;
        end
      end else if (txDivCnt != TXLAST) begin
        txDivCnt <= txDivCnt + TXW'(1);
      end else begin
        txDivCnt <= '0;
        case (txSt)
          START: begin
            txOutR   <= txShift[0];
            txShift  <= {1'b1, txShift[7:1]};
            txBitCnt <= '0;
            txSt     <= DATA;
          end
          DATA: begin
            if (txBitCnt == 3'd7) begin
              txOutR <= 1'b1;
              txSt   <= STOP;
            end else begin
              txOutR   <= txShift[0];
              txShift  <= {1'b1, txShift[7:1]};
              txBitCnt <= txBitCnt + 3'd1;
            end
          end
          default: begin
            // End of stop bit; a pending txStart chains the next frame with no gap.
            txDoneR <= 1'b1;
            if (bus.txStart) begin
              txShift <= bus.txIn;
              txOutR  <= 1'b0;
              txSt    <= START;
            end else begin
              txBusyR <= 1'b0;
              txSt    <= IDLE;
            end
          end
        endcase
      end
    end
  end

  assign bus.rxBusy  = rxBusyR;
  assign bus.rxDone  = rxDoneR;
  assign bus.rxErr   = rxErrR;
  assign bus.rxOut   = rxOutR;
  assign bus.txBusy  = txBusyR;
  assign bus.txDone  = txDoneR;
  assign bus.txOut   = txOutR;
  assign bus.rxState = rxSt;
  assign bus.txState = txSt;
endmodule

// File: tb/tb_uart8_core.sv
// Bench for uart8_core at scaled rates: 16 clocks per rx tick, 256 clocks per bit.
// A frame-position tx model and an rx expected-byte queue are checked every negedge.
`timescale 1ns/1ps
module tb_uart8_core;
  localparam int CLK_RATE = 2457600;
  localparam int BAUD     = 9600;
  localparam int BITCLK   = 256;

  logic clk = 1'b0;
  logic rst;
  logic rxLine;
  logic loopSel;

  uart8_core_if bus();
  assign bus.rxIn = loopSel ? bus.txOut : rxLine;

  uart8_core #(.CLOCK_RATE(CLK_RATE), .BAUD_RATE(BAUD)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  // clock / reset
  always #5 clk = ~clk;

  int nChecks = 0;
  int nErrors = 0;
  logic [8:0] exp_q[$];   // bit 8 set: framing error expected

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    nChecks++;
    if (act !== req) begin
      nErrors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic frameBit(input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
    return 1'b1;
  endfunction

  // model / scoreboard
  logic       seenRst = 1'b0;
  logic       rxHoldPrev = 1'b0;
  logic [7:0] modelRxOut = 8'h00;
  logic       txActive = 1'b0;
  int         txK = 0;
  logic [7:0] txByte = 8'h00;
  logic       expTxOut = 1'b1;
  logic       expTxBusy = 1'b0;
  logic       expTxDone = 1'b0;
  logic [8:0] expE;

  always @(negedge clk) begin
    if (seenRst) begin
      chk("txOut", bus.txOut, expTxOut);
      chk("txBusy", bus.txBusy, expTxBusy);
      chk("txDone", bus.txDone, expTxDone);
      if (bus.rxDone || bus.rxErr) begin
        if (exp_q.size() == 0) begin
          chk("rx unexpected pulse", {bus.rxErr, bus.rxDone}, 2'b00);
        end else begin
          expE = exp_q.pop_front();
          chk("rx pulse kind", {bus.rxErr, bus.rxDone}, expE[8] ? 2'b10 : 2'b01);
          if (!expE[8]) begin
            chk("rxOut on rxDone", bus.rxOut, expE[7:0]);
            modelRxOut = expE[7:0];
          end else begin
            chk("rxOut on rxErr", bus.rxOut, modelRxOut);
          end
        end
      end else begin
        chk("rxOut hold", bus.rxOut, modelRxOut);
      end
      if (rxHoldPrev) chk("rx held idle", {bus.rxBusy, bus.rxDone, bus.rxErr}, 3'b000);
    end
    if (rst) seenRst = 1'b1;
    // predict outputs after the coming edge from the inputs now applied
    rxHoldPrev = rst || !bus.rxEn;
    if (rst) modelRxOut = 8'h00;
    if (rst || !bus.txEn) begin
      txActive = 1'b0; expTxOut = 1'b1; expTxBusy = 1'b0; expTxDone = 1'b0;
    end else if (txActive) begin
      txK++;
      if (txK == 10 * BITCLK) begin
        expTxDone = 1'b1;
        if (bus.txStart) begin
          txK = 0; txByte = bus.txIn; expTxOut = 1'b0; expTxBusy = 1'b1;
        end else begin
          txActive = 1'b0; expTxOut = 1'b1; expTxBusy = 1'b0;
        end
      end else begin
        expTxDone = 1'b0; expTxOut = frameBit(txByte, txK / BITCLK); expTxBusy = 1'b1;
      end
    end else begin
      expTxDone = 1'b0;
      if (bus.txStart) begin
        txActive = 1'b1; txK = 0; txByte = bus.txIn; expTxOut = 1'b0; expTxBusy = 1'b1;
      end else begin
        expTxOut = 1'b1; expTxBusy = 1'b0;
      end
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic rxFrame(input logic [7:0] d, input int bitClks, input logic stopLvl, input int stopClks);
    exp_q.push_back({~stopLvl, d});
    rxLine = 1'b0;
    tick(bitClks);
    for (int i = 0; i < 8; i++) begin
      rxLine = d[i];
      tick(bitClks);
      if (i == 0) chk("rxBusy mid-frame", bus.rxBusy, 1'b1);
    end
    rxLine = stopLvl;
    tick(stopClks);
  endtask

  task automatic waitRx(input string name);
    for (int n = 0; n < 4000 && exp_q.size() != 0; n++) tick(1);
    chk(name, exp_q.size(), 0);
  endtask

  task automatic chkResetValues(input string tag);
    chk({tag, " rxBusy"}, bus.rxBusy, 1'b0);
    chk({tag, " rxDone"}, bus.rxDone, 1'b0);
    chk({tag, " rxErr"},  bus.rxErr,  1'b0);
    chk({tag, " rxOut"},  bus.rxOut,  8'h00);
    chk({tag, " txBusy"}, bus.txBusy, 1'b0);
    chk({tag, " txDone"}, bus.txDone, 1'b0);
    chk({tag, " txOut"},  bus.txOut,  1'b1);
  endtask

  logic [9:0] txLit = 10'b1110000110;   // 0xC3 framed, index 0 = start bit

  initial begin
    rst = 1'b1; rxLine = 1'b1; loopSel = 1'b0;
    bus.rxEn = 1'b1; bus.txEn = 1'b1; bus.txStart = 1'b0; bus.txIn = 8'h00;
    tick(3);
    chkResetValues("reset");
    rst = 1'b0;
    tick(20);

    // short low glitch rejected, then a 3% slow frame
    rxLine = 1'b0; tick(39);
    rxLine = 1'b1; tick(100);
    rxFrame(8'h56, 264, 1'b1, 264);
    tick(200);
    waitRx("glitch+0x56 pending");
    chk("rxOut after glitch+0x56", bus.rxOut, 8'h56);

    // short stop bit with next start immediately after
    rxFrame(8'h56, 256, 1'b1, 135);
    rxFrame(8'h9A, 256, 1'b1, 256);
    tick(100);
    waitRx("back-to-back pending");
    chk("rxOut after back-to-back", bus.rxOut, 8'h9A);

    // framing error keeps the previous byte
    rxFrame(8'hA5, 256, 1'b0, 200);
    rxLine = 1'b1;
    tick(400);
    waitRx("framing error pending");
    chk("rxOut after framing error", bus.rxOut, 8'h9A);

    // rxEn dropped after bit 3
    rxLine = 1'b0; tick(256);
    for (int i = 0; i < 4; i++) begin
      rxLine = (8'h5A >> i) & 1'b1;
      tick(256);
    end
    chk("rxBusy before rxEn drop", bus.rxBusy, 1'b1);
    bus.rxEn = 1'b0;
    tick(1);
    chk("rxBusy after rxEn drop", bus.rxBusy, 1'b0);
    for (int i = 4; i < 8; i++) begin
      rxLine = (8'h5A >> i) & 1'b1;
      tick(256);
    end
    rxLine = 1'b1; tick(300);
    bus.rxEn = 1'b1; tick(50);
    rxFrame(8'h3C, 248, 1'b1, 256);
    tick(100);
    waitRx("0x3C pending");
    chk("rxOut after abort+0x3C", bus.rxOut, 8'h3C);

    // tx 0xC3 in loopback, busy-time txStart/txIn ignored, chained 0x5A
    loopSel = 1'b1;
    bus.txIn = 8'hC3; bus.txStart = 1'b1;
    exp_q.push_back({1'b0, 8'hC3});
    tick(1);
    bus.txStart = 1'b0; bus.txIn = 8'hFF;
    tick(128);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("txOut 0xC3 bit %0d", i), bus.txOut, txLit[i]);
      if (i == 4) begin
        bus.txStart = 1'b1; tick(1);
        bus.txStart = 1'b0; tick(255);
      end else if (i < 9) begin
        tick(256);
      end
    end
    bus.txIn = 8'h5A; bus.txStart = 1'b1;
    exp_q.push_back({1'b0, 8'h5A});
    for (int n = 0; n < 300 && !bus.txDone; n++) tick(1);
    chk("txDone end of 0xC3", bus.txDone, 1'b1);
    chk("rxOut loopback 0xC3", bus.rxOut, 8'hC3);
    bus.txStart = 1'b0;
    for (int n = 0; n < 3000 && bus.txBusy; n++) tick(1);
    chk("txBusy drops after 0x5A", bus.txBusy, 1'b0);
    tick(100);
    waitRx("loopback pending");
    chk("rxOut loopback 0x5A", bus.rxOut, 8'h5A);
    loopSel = 1'b0;

    // txEn dropped mid-frame; txStart ignored while disabled
    bus.txIn = 8'hE7; bus.txStart = 1'b1; tick(1);
    bus.txStart = 1'b0; tick(1000);
    bus.txEn = 1'b0; bus.txStart = 1'b1; tick(1);
    chk("txOut after txEn drop", bus.txOut, 1'b1);
    chk("txBusy after txEn drop", bus.txBusy, 1'b0);
    tick(1);
    bus.txStart = 1'b0; tick(1700);
    bus.txEn = 1'b1; tick(10);

    // reset mid-rx and mid-tx
    rxLine = 1'b0; bus.txIn = 8'h81; bus.txStart = 1'b1; tick(1);
    bus.txStart = 1'b0; tick(400);
    chk("rxBusy before mid-frame rst", bus.rxBusy, 1'b1);
    chk("txBusy before mid-frame rst", bus.txBusy, 1'b1);
    rst = 1'b1; rxLine = 1'b1;
    tick(1);
    chkResetValues("mid-frame rst");
    rst = 1'b0;
    tick(3000);

    chk("rx expectations drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", nErrors, nChecks);
    $fatal(1);
  end
endmodule
